// File: rtl/spi_pkg.sv
// Shared SPI definitions: transmitter state encoding and the SPI mode constant.
package spi_pkg;

  // Transmitter FSM states; the receiver side decodes the same encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SCK_HI = 3'd2,
    ST_SCK_LO = 3'd3,
    ST_WAIT   = 3'd4,
    ST_HOLD   = 3'd5,
    ST_GAP    = 3'd6
  } spi_state_e;

  // SPI mode as {CPOL, CPHA}; mode 0 means SCK idles low and data is sampled on the rising edge.
  localparam logic [1:0] SPI_MODE = 2'b00;
  localparam logic       SCK_IDLE = SPI_MODE[1];

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider: while enabled, tick pulses once every H clk cycles.
// restart (or a disabled phase) returns the count to zero so each state
// starts a fresh half-period.
module spi_clk_div #(
  parameter int unsigned H = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(H - 1);

  logic [7:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count within one half-period; wrap on tick, clear on restart or when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || !en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_byte_tx.sv
// SPI mode-0 byte transmitter with frame control (CS held across bytes until
// tx_last or frame_end). All outputs are registered.
//
// Handshake: a byte is taken on a rising clk edge where tx_valid && tx_ready;
// tx_ready is high only in IDLE and WAIT, tx_valid at any other time is ignored
// and tx_data is only looked at on the accepting edge.
module spi_byte_tx
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  input  logic       frame_end,
  output logic       tx_ready,
  output logic       byte_done,
  output logic       busy,
  output logic       SCK,
  output logic       MOSI,
  output logic       CS,
  output spi_state_e state
);

  spi_state_e state_n;
  logic [7:0] sh, sh_n;
  logic [2:0] bit_cnt, bit_n;
  logic       last, last_n;
  logic       sck_n, mosi_n, cs_n, done_n, ready_n, busy_n;
  logic       accept, restart, en, tick;

  assign accept = tx_valid && tx_ready;
  assign en     = (state != ST_IDLE) && (state != ST_WAIT);

  spi_clk_div #(.H(CLK_DIV)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .restart (restart),
    .tick    (tick)
  );

  // Next-state and next-output logic; registers hold unless a transition fires.
  always_comb begin
    state_n = state;
    sh_n    = sh;
    bit_n   = bit_cnt;
    last_n  = last;
    sck_n   = SCK;
    mosi_n  = MOSI;
    cs_n    = CS;
    done_n  = 1'b0;
    restart = 1'b0;
    case (state)
      ST_IDLE, ST_WAIT: begin
        sck_n = SCK_IDLE;
        if (accept) begin
          sh_n    = tx_data;
          bit_n   = 3'd7;
          last_n  = tx_last;
          mosi_n  = tx_data[7];
          cs_n    = 1'b0;
          restart = 1'b1;
          state_n = ST_SETUP;
        end else if (state == ST_WAIT && frame_end) begin
          state_n = ST_HOLD;
        end
      end
      ST_SETUP, ST_SCK_LO: begin
        if (tick) begin
          sck_n   = 1'b1;
          state_n = ST_SCK_HI;
        end
      end
      ST_SCK_HI: begin
        if (tick) begin
          sck_n = 1'b0;
          if (bit_cnt != 3'd0) begin
            bit_n   = bit_cnt - 3'd1;
            sh_n    = {sh[6:0], 1'b0};
            mosi_n  = sh[6];
            state_n = ST_SCK_LO;
          end else begin
            done_n  = 1'b1;
            state_n = last ? ST_HOLD : ST_WAIT;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          cs_n    = 1'b1;
          state_n = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          mosi_n  = 1'b0;
          state_n = ST_IDLE;
        end
      end
      default: begin
        cs_n    = 1'b1;
        sck_n   = SCK_IDLE;
        mosi_n  = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
    ready_n = (state_n == ST_IDLE) || (state_n == ST_WAIT);
    busy_n  = (state_n != ST_IDLE);
  end

  // State, datapath and output registers; reset aborts any frame at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sh        <= '0;
      bit_cnt   <= '0;
      last      <= 1'b0;
      SCK       <= SCK_IDLE;
      MOSI      <= 1'b0;
      CS        <= 1'b1;
      byte_done <= 1'b0;
      tx_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      bit_cnt   <= bit_n;
      last      <= last_n;
      SCK       <= sck_n;
      MOSI      <= mosi_n;
      CS        <= cs_n;
      byte_done <= done_n;
      tx_ready  <= ready_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_spi_byte_tx.sv
// Bench for spi_byte_tx: one instance at CLK_DIV=2, one at CLK_DIV=1, each with
// a receiver model that shifts MOSI in on SCK rises and checks bytes against
// an expected queue when byte_done pulses.
module tb_spi_byte_tx;
  import spi_pkg::*;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance with CLK_DIV=2
  logic [7:0] data2 = '0;
  logic valid2 = 1'b0, last2 = 1'b0, fe2 = 1'b0;
  logic ready2, done2, busy2, sck2, mosi2, cs2;
  spi_state_e st2;

  // Instance with CLK_DIV=1
  logic [7:0] data1 = '0;
  logic valid1 = 1'b0, last1 = 1'b0, fe1 = 1'b0;
  logic ready1, done1, busy1, sck1, mosi1, cs1;
  spi_state_e st1;

  spi_byte_tx #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(data2), .tx_valid(valid2), .tx_last(last2),
    .frame_end(fe2), .tx_ready(ready2), .byte_done(done2), .busy(busy2),
    .SCK(sck2), .MOSI(mosi2), .CS(cs2), .state(st2)
  );

  spi_byte_tx #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(data1), .tx_valid(valid1), .tx_last(last1),
    .frame_end(fe1), .tx_ready(ready1), .byte_done(done1), .busy(busy1),
    .SCK(sck1), .MOSI(mosi1), .CS(cs1), .state(st1)
  );

  // Scoreboard state
  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] exp2_q[$];
  logic [7:0] exp1_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Receiver model for dut2
  logic sck2_q = 1'b0, mosi2_q = 1'b0, cs2_q = 1'b1;
  logic [7:0] rx2 = '0;
  int rises2 = 0, cs_low2 = 0, cs_rise2 = 0, done_cnt2 = 0;
  always @(negedge clk) begin
    if (sck2 && !sck2_q) begin
      rx2 = {rx2[6:0], mosi2};
      rises2++;
      check("mosi_stable2", 32'(mosi2), 32'(mosi2_q));
    end
    if (!cs2) cs_low2++;
    if (cs2 && !cs2_q) cs_rise2++;
    if (done2) begin
      done_cnt2++;
      if (exp2_q.size() == 0) check("byte2_expected", 32'(exp2_q.size()), 1);
      else check("rx_byte2", 32'(rx2), 32'(exp2_q.pop_front()));
    end
    sck2_q = sck2;
    mosi2_q = mosi2;
    cs2_q = cs2;
  end

  // Receiver model for dut1, also measuring the SCK period
  logic sck1_q = 1'b0;
  logic [7:0] rx1 = '0;
  int rises1 = 0, cyc1 = 0, last_rise1 = 0, period1 = 0;
  always @(negedge clk) begin
    cyc1++;
    if (sck1 && !sck1_q) begin
      rx1 = {rx1[6:0], mosi1};
      if (rises1 > 0) period1 = cyc1 - last_rise1;
      last_rise1 = cyc1;
      rises1++;
    end
    if (done1) begin
      if (exp1_q.size() == 0) check("byte1_expected", 32'(exp1_q.size()), 1);
      else check("rx_byte1", 32'(rx1), 32'(exp1_q.pop_front()));
    end
    sck1_q = sck1;
  end

  // Driver tasks: all sampling and driving happens just after the falling edge
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input int d, output int n);
    n = 0;
    while (!(d == 1 ? ready1 : ready2) && n < 500) begin step(); n++; end
    check("ready_seen", 32'(d == 1 ? ready1 : ready2), 1);
  endtask

  task automatic wait_done(input int d, output int n);
    n = 0;
    while (!(d == 1 ? done1 : done2) && n < 500) begin step(); n++; end
    check("done_seen", 32'(d == 1 ? done1 : done2), 1);
  endtask

  task automatic send(input int d, input logic [7:0] data, input logic last);
    int n;
    wait_ready(d, n);
    if (d == 1) begin
      data1 = data; last1 = last; valid1 = 1'b1; exp1_q.push_back(data);
    end else begin
      data2 = data; last2 = last; valid2 = 1'b1; exp2_q.push_back(data);
    end
    step();
    valid1 = 1'b0;
    valid2 = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Directed sequence
  initial begin
    int n, d0;
    repeat (3) step();
    check("rst_cs", 32'(cs2), 1);
    check("rst_sck", 32'(sck2), 0);
    check("rst_mosi", 32'(mosi2), 0);
    check("rst_ready", 32'(ready2), 0);
    check("rst_done", 32'(done2), 0);
    check("rst_busy", 32'(busy2), 0);
    rst_n = 1'b1;
    step();
    check("ready_after_rst", 32'(ready2), 1);
    check("idle_busy", 32'(busy2), 0);

    // 0xA5, single-byte frame
    rises2 = 0; cs_low2 = 0;
    send(2, 8'hA5, 1'b1);
    wait_done(2, n);
    check("a5_done_latency", n, 32);
    check("a5_rises", rises2, 8);
    wait_ready(2, n);
    check("a5_hold_gap", n, 4);
    check("a5_cs_low", cs_low2, 34);
    check("a5_cs_end", 32'(cs2), 1);

    // 0x3C then 0xC3 in one frame with 3 cycles in WAIT
    rises2 = 0; cs_rise2 = 0;
    send(2, 8'h3C, 1'b0);
    wait_done(2, n);
    check("3c_done_latency", n, 32);
    check("3c_ready_wait", 32'(ready2), 1);
    repeat (3) step();
    check("wait_cs_low", 32'(cs2), 0);
    check("wait_state", 32'(st2), 32'(ST_WAIT));
    check("wait_sck_low", 32'(sck2), 0);
    send(2, 8'hC3, 1'b1);
    wait_done(2, n);
    wait_ready(2, n);
    check("two_byte_rises", rises2, 16);
    check("two_byte_cs_rise", cs_rise2, 1);

    // 0x81 then frame_end; a stray frame_end mid-byte is ignored
    rises2 = 0;
    send(2, 8'h81, 1'b0);
    repeat (5) step();
    fe2 = 1'b1;
    step();
    fe2 = 1'b0;
    wait_done(2, n);
    step();
    check("81_in_wait", 32'(st2), 32'(ST_WAIT));
    check("81_cs_low", 32'(cs2), 0);
    fe2 = 1'b1;
    step();
    fe2 = 1'b0;
    n = 0;
    while (!cs2 && n < 50) begin step(); n++; end
    check("fe_hold_cycles", n, 2);
    wait_ready(2, n);
    check("81_rises", rises2, 8);

    // Reset in the 4th SCK_HI of 0xFF
    rises2 = 0;
    d0 = done_cnt2;
    send(2, 8'hFF, 1'b1);
    n = 0;
    while (rises2 < 4 && n < 200) begin step(); n++; end
    check("ff_reach_4th", rises2, 4);
    check("ff_in_sck_hi", 32'(st2), 32'(ST_SCK_HI));
    rst_n = 1'b0;
    #1;
    check("abort_cs", 32'(cs2), 1);
    check("abort_sck", 32'(sck2), 0);
    check("abort_mosi", 32'(mosi2), 0);
    check("abort_state", 32'(st2), 32'(ST_IDLE));
    exp2_q.delete();
    repeat (3) step();
    check("abort_no_done", done_cnt2, d0);
    rst_n = 1'b1;
    step();
    check("abort_ready", 32'(ready2), 1);

    // 0x55 after the abort
    rises2 = 0;
    send(2, 8'h55, 1'b1);
    wait_done(2, n);
    check("55_done_latency", n, 32);
    wait_ready(2, n);
    check("55_rises", rises2, 8);

    // tx_valid held high with changing tx_data while busy
    d0 = done_cnt2;
    send(2, 8'h5A, 1'b1);
    valid2 = 1'b1;
    n = 0;
    while (!done2 && n < 500) begin
      data2 = 8'($urandom_range(0, 255));
      step();
      n++;
    end
    valid2 = 1'b0;
    check("5a_ready_low", 32'(ready2), 0);
    wait_ready(2, n);
    check("5a_one_byte", done_cnt2 - d0, 1);
    check("5a_queue_empty", 32'(exp2_q.size()), 0);

    // CLK_DIV=1 instance
    rises1 = 0;
    send(1, 8'hA5, 1'b1);
    wait_done(1, n);
    check("div1_done_latency", n, 16);
    check("div1_period", period1, 2);
    check("div1_rises", rises1, 8);
    wait_ready(1, n);
    check("div1_hold_gap", n, 2);
    check("div1_busy", 32'(busy1), 0);
    check("div1_queue_empty", 32'(exp1_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
